lsu_bus_ctrl: RTL and testbench
===============================

# lsu_bus_ctrl

Load/store bus controller that sits directly downstream of the store byte-mask generator in the memory stage. It takes one load or store request, together with its byte-lane mask, and runs a single req/ack transaction on the data-memory bus. While the transaction is outstanding it stalls the pipeline. It returns load data already lane-extracted and sign- or zero-extended per `funct3`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: number of BUSY cycles without `bus_ack` before the access is aborted; 0 disables the timeout.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `memread`  in  1  load request from the memory stage.
- `memwrite`  in  1  store request; wins if asserted together with `memread`.
- `addr`  in  32  byte address.
- `funct3`  in  3  RISC-V load/store width code.
- `wdata`  in  32  unaligned store data (rs2).
- `mask`  in  4  byte-lane enables from the mask generator.
- `stall`  out  1  holds the pipeline while an access is pending.
- `rdata`  out  32  extended load result.
- `rdata_valid`  out  1  one-cycle pulse: `rdata` is valid.
- `bus_err`  out  1  one-cycle pulse: the access timed out.
- `misalign`  out  1  one-cycle pulse: the access was misaligned (only with the macro).
- `bus_req`, `bus_we`  out  1 each  bus request and write strobe.
- `bus_addr`  out  32  word-aligned address: `{addr[31:2],2'b00}`.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_be`  out  4  byte enables.
- `bus_ack`  in  1  bus completion.
- `bus_rdata`  in  32  bus read word.

## Operation
The controller has three states: IDLE, BUSY and DONE. Reset state is IDLE.

- **IDLE**
  - A request is `memread|memwrite`.
  - On a request, latch `addr`, `funct3` and `memwrite`.
  - Latch `bus_be`:
    - store: `mask`;
    - load: 4'b1111.
  - Latch `bus_wdata`:
    - byte (`funct3[1:0]`=00): `{4{wdata[7:0]}}`;
    - half (01): `{2{wdata[15:0]}}`;
    - otherwise: `wdata`.
  - Go to BUSY.
- **BUSY**
  - `bus_req`=1; all `bus_*` outputs are held stable.
  - The timeout counter increments every cycle.
  - On `bus_ack`:
    - load: capture the extracted result;
    - then go to DONE.
  - If the counter reaches `TIMEOUT_CYCLES` (nonzero) with no ack: set the error flag, force `rdata`=0, go to DONE.
  - Ack wins over timeout in the same cycle.
- **DONE**
  - `stall`=0 for exactly one cycle, so the pipeline advances.
  - `rdata_valid` pulses for loads that completed without error.
  - Request inputs are ignored in this state.
  - Always returns to IDLE.
- **`stall`**
  - `stall` = (IDLE & request) | BUSY.
  - The IDLE term is combinational from the request inputs.
- **Load extraction**, lane = `addr[1:0]`:
  - `funct3`=000 (LB): sign-extended byte.
  - 100 (LBU): zero-extended byte.
  - 001 (LH): half at `addr[1]`, sign-extended.
  - 101 (LHU): half at `addr[1]`, zero-extended.
  - 010 and any other code: full word.
- **Extension widths**: byte to 32 bits = 24 fill bits; half to 32 bits = 16 fill bits.
- **Timeout counter**: width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1; it is cleared on entry to BUSY.

## Timing
- **Reset values**: every output is 0; state is IDLE.
  - Reset mid-transaction drops `bus_req` immediately (asynchronous).
  - No pulse outputs fire during or after reset.
- **Request timing**:
  - Request seen in cycle 0.
  - `bus_req` high from cycle 1.
  - `bus_ack` is sampled only while `bus_req`=1.
  - Ack in cycle k (k≥1) → DONE in cycle k+1.
- **Minimum occupancy**: 3 cycles (IDLE, BUSY, DONE) with `stall` high for 2 of them.
- **Load pulses**: `rdata` and `rdata_valid` are registered and valid only in the DONE cycle. `rdata` holds its value afterward until the next load completes.
- **Back-to-back requests**: a new request is accepted only in the IDLE cycle after DONE.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined**:
  - A misaligned access in IDLE issues no bus transaction. Misaligned means a half with `addr[0]`=1, or a word with `addr[1:0]`≠0.
  - `stall`=1 in that IDLE cycle, then DONE with `misalign`=1 for one cycle.
  - `rdata_valid`=0 and `rdata` is unchanged.
- **Not defined**:
  - `misalign` is tied to 0.
  - The low address bits are used as given; LH at `addr`=3 returns the upper half.

## Test plan
- **Store byte**: SB, `addr`=0x1003, `wdata`=0x000000A5, `mask`=4'b1000 → in BUSY, `bus_addr`=0x1000, `bus_wdata`=0xA5A5A5A5, `bus_be`=4'b1000, `bus_we`=1. Ack in cycle 2 → DONE in cycle 3 with no `rdata_valid`.
- **Load sign/zero extension**: LB then LBU, `addr`=0x2002, `bus_rdata`=0x12F03456 → `rdata`=0xFFFFFFF0 then 0x000000F0. `rdata_valid` pulses once per load.
- **Load half**: LH, `addr`=0x2002, `bus_rdata`=0x80011234 → `rdata`=0xFFFF8001. With a 5-cycle ack delay, `stall` stays high for exactly 6 cycles.
- **Timeout**: `TIMEOUT_CYCLES`=4, no ack → `bus_err` pulses in the cycle after the 4th BUSY cycle, `rdata`=0, `bus_req` drops, state returns to IDLE.
- **Reset mid-access**: assert `rst` in the middle of BUSY → `bus_req`, `stall` and `rdata` are 0 immediately. After release, a new LW at 0x0 completes normally.
- **Misaligned word**: LW at 0x3001 → with `LSU_MISALIGN_TRAP_EN`, `bus_req` never asserts and `misalign` pulses. Without the macro, `bus_addr`=0x3000 and the full word is returned.

Source files
------------

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store req/ack bus controller for the memory stage.
// Runs one bus transaction per request, stalls the pipeline meanwhile and
// returns lane-extracted, sign/zero-extended load data.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word
// accesses instead of issuing them on the bus).
module lsu_bus_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [3:0]  mask,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        bus_err,
   output logic        misalign,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   // Counter value seen in the last BUSY cycle before the access is abandoned
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic             req;
   logic             timeout_hit;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       lat_lane;
   logic [2:0]       lat_f3;
   logic             lat_we;

   // Pick the addressed byte/half out of the bus word and extend it to 32 bits
   function automatic logic [31:0] extract(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [2:0]  f3);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] sx;
      b  = word[{lane, 3'b000} +: 8];
      h  = lane[1] ? word[31:16] : word[15:0];
      sx = 32'sd0;
      case (f3)
         3'b000:  begin sx = b; extract = sx; end
         3'b100:  extract = {24'd0, b};
         3'b001:  begin sx = h; extract = sx; end
         3'b101:  extract = {16'd0, h};
         default: extract = word;
      endcase
   endfunction

   // Replicate store data across lanes so the byte enables pick the right copy
   function automatic logic [31:0] replicate(input logic [31:0] d, input logic [1:0] sz);
      case (sz)
         2'b00:   replicate = {4{d[7:0]}};
         2'b01:   replicate = {2{d[15:0]}};
         default: replicate = d;
      endcase
   endfunction

   assign req         = memread | memwrite;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

   // Pipeline hold: combinational on the request while idle, then for all of BUSY
   always_comb begin
      stall = 1'b0;
      if (!rst)
         stall = ((state == IDLE) && req) || (state == BUSY);
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic trap;

   // Half with odd address or word not on a 4-byte boundary
   always_comb begin
      trap = 1'b0;
      if (funct3[1:0] == 2'b01)
         trap = addr[0];
      else if (funct3[1:0] == 2'b10)
         trap = (addr[1:0] != 2'b00);
   end
`else
   assign misalign = 1'b0;
`endif

   // Controller FSM with all bus and result outputs registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         lat_lane    <= 2'b00;
         lat_f3      <= 3'b000;
         lat_we      <= 1'b0;
         rdata       <= 32'd0;
         rdata_valid <= 1'b0;
         bus_err     <= 1'b0;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= 32'd0;
         bus_wdata   <= 32'd0;
         bus_be      <= 4'd0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign    <= 1'b0;
`endif
      end else begin
         rdata_valid <= 1'b0;
         bus_err     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (req) begin
`ifdef LSU_MISALIGN_TRAP_EN
                  if (trap) begin
                     state    <= DONE;
                     misalign <= 1'b1;
                  end else
`endif
                  begin
                     state     <= BUSY;
                     cnt       <= '0;
                     lat_lane  <= addr[1:0];
                     lat_f3    <= funct3;
                     lat_we    <= memwrite;
                     bus_req   <= 1'b1;
                     bus_we    <= memwrite;
                     bus_addr  <= {addr[31:2], 2'b00};
                     bus_wdata <= replicate(wdata, funct3[1:0]);
                     bus_be    <= memwrite ? mask : 4'b1111;
                  end
               end
            end
            BUSY: begin
               if (bus_ack) begin
                  state   <= DONE;
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  if (!lat_we) begin
                     rdata       <= extract(bus_rdata, lat_lane, lat_f3);
                     rdata_valid <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  state   <= DONE;
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  bus_err <= 1'b1;
                  rdata   <= 32'd0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed self-checking bench for lsu_bus_ctrl.
// Main instance uses the default timeout; a second instance with a 4-cycle
// timeout is used for the abort path.
module tb_lsu_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        memread = 1'b0, memwrite = 1'b0;
   logic [31:0] addr = 32'd0, wdata = 32'd0, bus_rdata = 32'd0;
   logic [2:0]  funct3 = 3'd0;
   logic [3:0]  mask = 4'd0;
   logic        bus_ack = 1'b0;
   logic        stall, rdata_valid, bus_err, misalign, bus_req, bus_we;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_be;

   logic        rd_to = 1'b0, ack_to = 1'b0;
   logic        stall_to, rdata_valid_to, bus_err_to, misalign_to, bus_req_to, bus_we_to;
   logic [31:0] rdata_to, bus_addr_to, bus_wdata_to;
   logic [3:0]  bus_be_to;

   int checks = 0;
   int failures = 0;
   int nst;
   logic [31:0] ba;

   always #5 clk = ~clk;

   lsu_bus_ctrl dut (
      .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite), .addr(addr),
      .funct3(funct3), .wdata(wdata), .mask(mask), .stall(stall), .rdata(rdata),
      .rdata_valid(rdata_valid), .bus_err(bus_err), .misalign(misalign),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   lsu_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .rst(rst), .memread(rd_to), .memwrite(1'b0), .addr(addr),
      .funct3(funct3), .wdata(wdata), .mask(mask), .stall(stall_to), .rdata(rdata_to),
      .rdata_valid(rdata_valid_to), .bus_err(bus_err_to), .misalign(misalign_to),
      .bus_req(bus_req_to), .bus_we(bus_we_to), .bus_addr(bus_addr_to),
      .bus_wdata(bus_wdata_to), .bus_be(bus_be_to), .bus_ack(ack_to), .bus_rdata(bus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access on the main instance starting at a negedge; ack driven in cycle ack_at.
   // Returns at the negedge of the DONE cycle with the stall-cycle count and BUSY bus_addr.
   task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m, input logic [31:0] rw,
                         input int ack_at, output int n, output logic [31:0] addr_seen);
      n = 0;
      addr_seen = 32'hx;
      memread = ~wr; memwrite = wr; funct3 = f3; addr = a; wdata = wd; mask = m;
      for (int c = 0; c <= ack_at; c++) begin
         if (c == ack_at) begin bus_ack = 1'b1; bus_rdata = rw; end
         #1;
         if (stall) n++;
         if (c == 1) addr_seen = bus_addr;
         @(negedge clk);
         memread = 1'b0; memwrite = 1'b0; bus_ack = 1'b0;
      end
      #1;
      if (stall) n++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_stall", stall, 0);
      chk("rst_bus_req", bus_req, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_pulses", {rdata_valid, bus_err, misalign}, 0);
      chk("rst_bus_addr", bus_addr, 0);
      rst = 1'b0;
      @(negedge clk);

      // Store byte
      memwrite = 1'b1; funct3 = 3'b000; addr = 32'h1003; wdata = 32'h000000A5; mask = 4'b1000;
      #1;
      chk("sb_c0_stall", stall, 1);
      chk("sb_c0_req", bus_req, 0);
      @(negedge clk);
      memwrite = 1'b0;
      #1;
      chk("sb_bus_req", bus_req, 1);
      chk("sb_bus_addr", bus_addr, 32'h1000);
      chk("sb_bus_wdata", bus_wdata, 32'hA5A5A5A5);
      chk("sb_bus_be", bus_be, 4'b1000);
      chk("sb_bus_we", bus_we, 1);
      @(negedge clk);
      chk("sb_c2_stall", stall, 1);
      chk("sb_c2_addr_stable", bus_addr, 32'h1000);
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      chk("sb_done_stall", stall, 0);
      chk("sb_done_req", bus_req, 0);
      chk("sb_done_valid", rdata_valid, 0);
      @(negedge clk);
      chk("sb_idle_stall", stall, 0);

      // LB / LBU lane 2
      access(1'b0, 3'b000, 32'h2002, 0, 0, 32'h12F03456, 1, nst, ba);
      chk("lb_rdata", rdata, 32'hFFFFFFF0);
      chk("lb_valid", rdata_valid, 1);
      chk("lb_min_stall", nst, 2);
      @(negedge clk);
      chk("lb_valid_pulse", rdata_valid, 0);
      access(1'b0, 3'b100, 32'h2002, 0, 0, 32'h12F03456, 1, nst, ba);
      chk("lbu_rdata", rdata, 32'h000000F0);
      chk("lbu_valid", rdata_valid, 1);
      @(negedge clk);

      // LH with 5-cycle ack delay
      access(1'b0, 3'b001, 32'h2002, 0, 0, 32'h80011234, 5, nst, ba);
      chk("lh_rdata", rdata, 32'hFFFF8001);
      chk("lh_stall_cycles", nst, 6);
      chk("lh_bus_addr", ba, 32'h2000);
      @(negedge clk);
      access(1'b0, 3'b101, 32'h2000, 0, 0, 32'h80011234, 2, nst, ba);
      chk("lhu_rdata", rdata, 32'h00001234);
      @(negedge clk);

      // Store after load leaves rdata untouched
      access(1'b1, 3'b010, 32'h40, 32'h11223344, 4'b1111, 32'hFFFFFFFF, 1, nst, ba);
      chk("sw_rdata_hold", rdata, 32'h00001234);
      chk("sw_no_valid", rdata_valid, 0);
      @(negedge clk);
      chk("sw_rdata_hold2", rdata, 32'h00001234);

      // Timeout instance: good load first, then an unacknowledged one
      rd_to = 1'b1; funct3 = 3'b010; addr = 32'h0;
      @(negedge clk);
      rd_to = 1'b0; ack_to = 1'b1; bus_rdata = 32'h5555AAAA;
      @(negedge clk);
      ack_to = 1'b0;
      chk("to_first_rdata", rdata_to, 32'h5555AAAA);
      @(negedge clk);
      rd_to = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         rd_to = 1'b0;
         chk("to_busy_req", bus_req_to, 1);
         chk("to_busy_err", bus_err_to, 0);
      end
      @(negedge clk);
      chk("to_err", bus_err_to, 1);
      chk("to_req_drop", bus_req_to, 0);
      chk("to_rdata_zero", rdata_to, 0);
      chk("to_no_valid", rdata_valid_to, 0);
      chk("to_done_stall", stall_to, 0);
      @(negedge clk);
      chk("to_err_pulse", bus_err_to, 0);
      chk("to_idle_stall", stall_to, 0);

      // Reset in the middle of BUSY
      memread = 1'b1; funct3 = 3'b010; addr = 32'h0;
      @(negedge clk);
      memread = 1'b0;
      #1;
      chk("rm_busy_req", bus_req, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rm_req", bus_req, 0);
      chk("rm_stall", stall, 0);
      chk("rm_rdata", rdata, 0);
      @(negedge clk);
      chk("rm_pulses", {rdata_valid, bus_err}, 0);
      rst = 1'b0;
      @(negedge clk);
      access(1'b0, 3'b010, 32'h0, 0, 0, 32'hCAFEF00D, 1, nst, ba);
      chk("rm_lw_rdata", rdata, 32'hCAFEF00D);
      chk("rm_lw_valid", rdata_valid, 1);
      @(negedge clk);

      // Misaligned word
`ifdef LSU_MISALIGN_TRAP_EN
      memread = 1'b1; funct3 = 3'b010; addr = 32'h3001;
      #1;
      chk("ma_c0_stall", stall, 1);
      @(negedge clk);
      memread = 1'b0;
      #1;
      chk("ma_no_req", bus_req, 0);
      chk("ma_pulse", misalign, 1);
      chk("ma_no_valid", rdata_valid, 0);
      chk("ma_rdata_hold", rdata, 32'hCAFEF00D);
      chk("ma_done_stall", stall, 0);
      @(negedge clk);
      chk("ma_pulse_end", misalign, 0);
      chk("ma_still_no_req", bus_req, 0);
`else
      access(1'b0, 3'b010, 32'h3001, 0, 0, 32'hDEADBEEF, 1, nst, ba);
      chk("ma_bus_addr", ba, 32'h3000);
      chk("ma_rdata", rdata, 32'hDEADBEEF);
      chk("ma_no_trap", misalign, 0);
`endif
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
